// File: rtl/pic_uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pic_uart_pkg
// Brief    : Shared types, SFR bit positions and baud helpers for pic_uart.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package pic_uart_pkg;

  typedef enum logic [1:0] {
    TX_STOP  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int TXSTA_CSRC  = 7;
  localparam int TXSTA_TX9   = 6;
  localparam int TXSTA_TXEN  = 5;
  localparam int TXSTA_SYNC  = 4;
  localparam int TXSTA_BRGH  = 2;
  localparam int TXSTA_TRMT  = 1;
  localparam int TXSTA_TX9D  = 0;

  localparam int RCSTA_SPEN  = 7;
  localparam int RCSTA_RX9   = 6;
  localparam int RCSTA_SREN  = 5;
  localparam int RCSTA_CREN  = 4;
  localparam int RCSTA_ADDEN = 3;
  localparam int RCSTA_FERR  = 2;

  // Bits that software can actually store; everything else is derived or zero.
  localparam logic [7:0] TXSTA_WMASK = 8'((1 << TXSTA_CSRC) | (1 << TXSTA_TX9) |
                                          (1 << TXSTA_TXEN) | (1 << TXSTA_SYNC) |
                                          (1 << TXSTA_BRGH) | (1 << TXSTA_TX9D));
  localparam logic [7:0] RCSTA_WMASK = 8'((1 << RCSTA_SPEN) | (1 << RCSTA_RX9) |
                                          (1 << RCSTA_SREN) | (1 << RCSTA_CREN) |
                                          (1 << RCSTA_ADDEN));

  localparam logic [7:0] TXSTA_RST   = 8'h02;
  localparam int         BAUD_MUL_HI = 16;
  localparam int         BAUD_MUL_LO = 64;
  localparam int         BAUD_W      = 15;

  function automatic logic [BAUD_W-1:0] baud_period(input logic [7:0] spbrg,
                                                    input logic       brgh);
    logic [BAUD_W-1:0] div;
    div = BAUD_W'({1'b0, spbrg}) + BAUD_W'(1);
    return brgh ? div * BAUD_W'(BAUD_MUL_HI) : div * BAUD_W'(BAUD_MUL_LO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pic_uart_rx
// Brief    : 8N1 receiver with 2-flop synchroniser and mid-bit sampling.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module pic_uart_rx
  import pic_uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic              en,
  input  logic [BAUD_W-1:0] baud_n,
  output logic              done,
  output logic [7:0]        data,
  output logic              stop_bit
);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;
  rx_state_t         r_state;
  logic [BAUD_W-1:0] r_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;

  logic [BAUD_W-1:0] w_half_last;
  logic [BAUD_W-1:0] w_full_last;

  assign w_half_last = (baud_n >> 1) - BAUD_W'(1);
  assign w_full_last = baud_n - BAUD_W'(1);
  assign done        = en && (r_state == RX_STOP) && (r_cnt == w_full_last);
  assign data        = r_shift;
  assign stop_bit    = r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else if (!en) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_prev && !r_sync2) r_state <= RX_START;
        end
        RX_START: begin
          // Half a bit in: a line that is high again was only a glitch.
          if (r_cnt == w_half_last) begin
            r_cnt <= '0;
            if (!r_sync2) begin
              r_state   <= RX_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= RX_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + BAUD_W'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == w_full_last) begin
            r_cnt     <= '0;
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + BAUD_W'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == w_full_last) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + BAUD_W'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pic_uart.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pic_uart
// Brief    : PIC16F-style 8N1 UART with TXSTA/RCSTA/SPBRG/TXREG/RXREG SFRs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module pic_uart
  import pic_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic       UART_TXD,
  input  logic       UART_RXD,
  input  logic [7:0] reg_data_in,
  input  logic       txsta_reg_wr_en,
  output logic [7:0] txsta_reg_out,
  input  logic       rcsta_reg_wr_en,
  output logic [7:0] rcsta_reg_out,
  input  logic       spbrg_reg_wr_en,
  output logic [7:0] spbrg_reg_out,
  input  logic       txreg_reg_wr_en,
  output logic [7:0] txreg_reg_out,
  input  logic       rxreg_reg_wr_en,
  output logic [7:0] rxreg_reg_out,
  output logic       txif_set_en,
  output logic       rxif_set_en
);

  logic [7:0]        r_txsta;
  logic [7:0]        r_rcsta;
  logic [7:0]        r_spbrg;
  logic [7:0]        r_txreg;
  logic [7:0]        r_rxreg;
  logic              r_ferr;
  logic              r_rxif;
  logic              r_pending;
  logic              r_consumed;
  logic              r_tsr_full;
  logic [7:0]        r_tsr;
  logic              r_txd;
  tx_state_t         r_tx_state;
  logic [2:0]        r_bit_idx;
  logic [BAUD_W-1:0] r_baud_cnt;

  logic [BAUD_W-1:0] w_baud_n;
  logic              w_tick;
  logic              w_txen;
  logic              w_load;
  logic              w_rx_en;
  logic              w_rx_done;
  logic              w_rx_stop;
  logic [7:0]        w_rx_data;

  assign w_baud_n = baud_period(r_spbrg, r_txsta[TXSTA_BRGH]);
  assign w_tick   = (r_baud_cnt == '0);
  assign w_txen   = r_txsta[TXSTA_TXEN];
  assign w_load   = r_pending && !r_tsr_full && w_txen;
  assign w_rx_en  = r_rcsta[RCSTA_SPEN] && r_rcsta[RCSTA_CREN];

  assign UART_TXD      = r_txd;
  assign txsta_reg_out = (r_txsta & TXSTA_WMASK) | (8'(!r_tsr_full) << TXSTA_TRMT);
  assign rcsta_reg_out = r_rcsta | (8'(r_ferr) << RCSTA_FERR);
  assign spbrg_reg_out = r_spbrg;
  assign txreg_reg_out = r_txreg;
  assign rxreg_reg_out = r_rxreg;
  assign txif_set_en   = !r_pending;
  assign rxif_set_en   = r_rxif;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txsta <= TXSTA_RST;
      r_rcsta <= 8'h00;
      r_spbrg <= 8'h00;
      r_txreg <= 8'h00;
      r_rxreg <= 8'h00;
      r_ferr  <= 1'b0;
      r_rxif  <= 1'b0;
    end else begin
      if (txsta_reg_wr_en) r_txsta <= reg_data_in & TXSTA_WMASK;
      if (rcsta_reg_wr_en) r_rcsta <= reg_data_in & RCSTA_WMASK;
      if (spbrg_reg_wr_en) r_spbrg <= reg_data_in;
      if (txreg_reg_wr_en) r_txreg <= reg_data_in;
      if (w_rx_done) begin
        r_rxreg <= w_rx_data;
        r_ferr  <= !w_rx_stop;
      end else if (rxreg_reg_wr_en) begin
        r_rxreg <= reg_data_in;
      end
      r_rxif <= w_rx_done;
    end
  end

  // The wrap compare is >= so a shrinking SPBRG/BRGH never strands the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud_cnt <= '0;
    end else if (r_baud_cnt >= w_baud_n - BAUD_W'(1)) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending  <= 1'b0;
      r_consumed <= 1'b0;
    end else begin
      if (txreg_reg_wr_en) r_pending <= 1'b1;
      else if (r_consumed) r_pending <= 1'b0;
      r_consumed <= w_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_STOP;
      r_txd      <= 1'b1;
      r_tsr_full <= 1'b0;
      r_tsr      <= 8'h00;
      r_bit_idx  <= 3'd0;
    end else if (!w_txen) begin
      r_tx_state <= TX_STOP;
      r_txd      <= 1'b1;
      r_tsr_full <= 1'b0;
    end else begin
      if (w_load) begin
        r_tsr      <= r_txreg;
        r_tsr_full <= 1'b1;
      end
      if (w_tick) begin
        case (r_tx_state)
          TX_STOP: begin
            if (r_tsr_full) begin
              r_tx_state <= TX_START;
              r_txd      <= 1'b0;
            end
          end
          TX_START: begin
            r_tx_state <= TX_DATA;
            r_bit_idx  <= 3'd0;
            r_txd      <= r_tsr[0];
            r_tsr      <= r_tsr >> 1;
          end
          TX_DATA: begin
            if (r_bit_idx == 3'd7) begin
              r_tx_state <= TX_STOP;
              r_txd      <= 1'b1;
              r_tsr_full <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_tsr[0];
              r_tsr     <= r_tsr >> 1;
            end
          end
          default: r_tx_state <= TX_STOP;
        endcase
      end
    end
  end

  pic_uart_rx u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (UART_RXD),
    .en       (w_rx_en),
    .baud_n   (w_baud_n),
    .done     (w_rx_done),
    .data     (w_rx_data),
    .stop_bit (w_rx_stop)
  );

endmodule
`default_nettype wire

// File: tb/tb_pic_uart.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_pic_uart
// Brief    : Directed self-checking bench for pic_uart.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pic_uart;

  localparam int SEL_TXSTA = 0;
  localparam int SEL_RCSTA = 1;
  localparam int SEL_SPBRG = 2;
  localparam int SEL_TXREG = 3;
  localparam int SEL_RXREG = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       UART_TXD;
  logic       UART_RXD = 1'b1;
  logic [7:0] reg_data_in = 8'h00;
  logic       txsta_reg_wr_en = 1'b0;
  logic       rcsta_reg_wr_en = 1'b0;
  logic       spbrg_reg_wr_en = 1'b0;
  logic       txreg_reg_wr_en = 1'b0;
  logic       rxreg_reg_wr_en = 1'b0;
  logic [7:0] txsta_reg_out;
  logic [7:0] rcsta_reg_out;
  logic [7:0] spbrg_reg_out;
  logic [7:0] txreg_reg_out;
  logic [7:0] rxreg_reg_out;
  logic       txif_set_en;
  logic       rxif_set_en;

  int total = 0;
  int bad   = 0;
  int rxif_cnt = 0;

  pic_uart dut (
    .clk             (clk),
    .rst             (rst),
    .UART_TXD        (UART_TXD),
    .UART_RXD        (UART_RXD),
    .reg_data_in     (reg_data_in),
    .txsta_reg_wr_en (txsta_reg_wr_en),
    .txsta_reg_out   (txsta_reg_out),
    .rcsta_reg_wr_en (rcsta_reg_wr_en),
    .rcsta_reg_out   (rcsta_reg_out),
    .spbrg_reg_wr_en (spbrg_reg_wr_en),
    .spbrg_reg_out   (spbrg_reg_out),
    .txreg_reg_wr_en (txreg_reg_wr_en),
    .txreg_reg_out   (txreg_reg_out),
    .rxreg_reg_wr_en (rxreg_reg_wr_en),
    .rxreg_reg_out   (rxreg_reg_out),
    .txif_set_en     (txif_set_en),
    .rxif_set_en     (rxif_set_en)
  );

  always #5 clk = ~clk;

  // Counts high cycles, so a pulse wider than one clock shows up as extra counts.
  always @(posedge clk) if (rxif_set_en === 1'b1) rxif_cnt <= rxif_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int sel, input logic [7:0] d);
    @(negedge clk);
    reg_data_in = d;
    case (sel)
      SEL_TXSTA: txsta_reg_wr_en = 1'b1;
      SEL_RCSTA: rcsta_reg_wr_en = 1'b1;
      SEL_SPBRG: spbrg_reg_wr_en = 1'b1;
      SEL_TXREG: txreg_reg_wr_en = 1'b1;
      default:   rxreg_reg_wr_en = 1'b1;
    endcase
    @(negedge clk);
    txsta_reg_wr_en = 1'b0;
    rcsta_reg_wr_en = 1'b0;
    spbrg_reg_wr_en = 1'b0;
    txreg_reg_wr_en = 1'b0;
    rxreg_reg_wr_en = 1'b0;
  endtask

  task automatic wait_txd_low(input int limit);
    int c = 0;
    while (UART_TXD !== 1'b0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk("txd_start_seen", UART_TXD, 1'b0);
  endtask

  // Entered on the first sample of the start bit; returns on the last stop-bit sample.
  task automatic check_frame(input logic [7:0] d, input int n,
                             input logic nxt, input logic [7:0] nd);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("txd_bit%0d_first", i), UART_TXD, bits[i]);
      if (i == 4) chk("trmt_busy", txsta_reg_out[1], 1'b0);
      if (i == 9) begin
        chk("trmt_after_frame", txsta_reg_out[1], 1'b1);
        if (nxt) begin
          wr(SEL_TXREG, nd);
          repeat (n - 3) @(negedge clk);
        end else begin
          repeat (n - 1) @(negedge clk);
        end
      end else begin
        repeat (n - 1) @(negedge clk);
      end
      chk($sformatf("txd_bit%0d_last", i), UART_TXD, bits[i]);
      if (i < 9) @(negedge clk);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_RXD = bits[i];
      repeat (16) @(negedge clk);
    end
    UART_RXD = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_txsta", txsta_reg_out, 8'h02);
    chk("rst_rcsta", rcsta_reg_out, 8'h00);
    chk("rst_spbrg", spbrg_reg_out, 8'h00);
    chk("rst_txreg", txreg_reg_out, 8'h00);
    chk("rst_rxreg", rxreg_reg_out, 8'h00);
    chk("rst_txif", txif_set_en, 1'b1);
    chk("rst_rxif", rxif_set_en, 1'b0);
    chk("rst_txd", UART_TXD, 1'b1);

    // N = 16: handoff, frame 0xCA, then 0x3C queued during the stop bit
    wr(SEL_TXSTA, 8'h24);
    wr(SEL_SPBRG, 8'h00);
    chk("txsta_rd", txsta_reg_out, 8'h26);
    wr(SEL_TXREG, 8'hCA);
    chk("txif_at_w", txif_set_en, 1'b0);
    @(negedge clk);
    chk("txif_w1", txif_set_en, 1'b0);
    chk("trmt_w1", txsta_reg_out[1], 1'b0);
    @(negedge clk);
    chk("txif_w2", txif_set_en, 1'b1);
    wait_txd_low(64);
    check_frame(8'hCA, 16, 1'b1, 8'h3C);
    @(negedge clk);
    chk("b2b_no_gap", UART_TXD, 1'b0);
    chk("b2b_txreg", txreg_reg_out, 8'h3C);
    check_frame(8'h3C, 16, 1'b0, 8'h00);
    @(negedge clk);
    chk("idle_txd", UART_TXD, 1'b1);
    chk("idle_trmt", txsta_reg_out[1], 1'b1);

    // N = 64*(2+1) = 192
    wr(SEL_SPBRG, 8'h02);
    wr(SEL_TXSTA, 8'h20);
    chk("txsta_lo", txsta_reg_out, 8'h22);
    wr(SEL_TXREG, 8'hA5);
    wait_txd_low(500);
    check_frame(8'hA5, 192, 1'b0, 8'h00);

    // TXEN cleared mid-frame
    wr(SEL_TXREG, 8'h00);
    wait_txd_low(500);
    repeat (384) @(negedge clk);
    chk("abort_mid_low", UART_TXD, 1'b0);
    wr(SEL_TXSTA, 8'h00);
    @(negedge clk);
    chk("abort_txd", UART_TXD, 1'b1);
    chk("abort_trmt", txsta_reg_out[1], 1'b1);
    repeat (300) @(negedge clk);
    chk("abort_stays_idle", UART_TXD, 1'b1);

    // TXREG written while disabled stays pending until TXEN returns
    wr(SEL_SPBRG, 8'h00);
    wr(SEL_TXREG, 8'h81);
    repeat (20) @(negedge clk);
    chk("hold_txif", txif_set_en, 1'b0);
    chk("hold_trmt", txsta_reg_out[1], 1'b1);
    chk("hold_txd", UART_TXD, 1'b1);
    wr(SEL_TXSTA, 8'h24);
    @(negedge clk);
    chk("reen_trmt", txsta_reg_out[1], 1'b0);
    @(negedge clk);
    chk("reen_txif", txif_set_en, 1'b1);
    wait_txd_low(64);
    check_frame(8'h81, 16, 1'b0, 8'h00);

    // Receiver at N = 16
    wr(SEL_RCSTA, 8'h90);
    send_rx(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    chk("rx_data", rxreg_reg_out, 8'h5A);
    chk("rx_ferr0", rcsta_reg_out, 8'h90);
    chk("rx_pulse", 16'(rxif_cnt), 16'd1);
    send_rx(8'h33, 1'b0);
    repeat (20) @(negedge clk);
    chk("rx_data_ferr", rxreg_reg_out, 8'h33);
    chk("rx_ferr1", rcsta_reg_out, 8'h94);
    chk("rx_pulse2", 16'(rxif_cnt), 16'd2);
    wr(SEL_RXREG, 8'h11);
    @(negedge clk);
    chk("rxreg_sw", rxreg_reg_out, 8'h11);
    chk("rxreg_sw_nopulse", 16'(rxif_cnt), 16'd2);
    UART_RXD = 1'b0;
    repeat (3) @(negedge clk);
    UART_RXD = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_nopulse", 16'(rxif_cnt), 16'd2);
    chk("glitch_rxreg", rxreg_reg_out, 8'h11);
    wr(SEL_RCSTA, 8'h80);
    chk("rcsta_cren_off", rcsta_reg_out, 8'h84);
    send_rx(8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    chk("rx_disabled_data", rxreg_reg_out, 8'h11);
    chk("rx_disabled_pulse", 16'(rxif_cnt), 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pic_uart.md
Name: pic_uart

Overview:
- PIC16F-style asynchronous UART peripheral with 8-bit data, 1 start bit, 1 stop bit and LSB-first transmission.
- Exposes the SFRs TXSTA, RCSTA, SPBRG, TXREG and RXREG on the core's shared register write bus.
- Produces strobes that set the core's TXIF and RXIF interrupt flags.
- Sits beside the PIC core's SFR file and drives the board UART pins.

Parameters:
- None. Frame format is fixed at 8N1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- UART_TXD  out  1  serial transmit line; idles high
- UART_RXD  in  1  serial receive line; asynchronous
- reg_data_in  in  8  SFR write data bus
- txsta_reg_wr_en  in  1  write strobe for TXSTA
- txsta_reg_out  out  8  TXSTA readback
- rcsta_reg_wr_en  in  1  write strobe for RCSTA
- rcsta_reg_out  out  8  RCSTA readback
- spbrg_reg_wr_en  in  1  write strobe for SPBRG
- spbrg_reg_out  out  8  SPBRG readback
- txreg_reg_wr_en  in  1  write strobe for TXREG; a write queues the byte for transmission
- txreg_reg_out  out  8  TXREG readback
- rxreg_reg_wr_en  in  1  software write strobe for RXREG
- rxreg_reg_out  out  8  RXREG readback (last received byte)
- txif_set_en  out  1  high whenever TXREG holds no unconsumed data
- rxif_set_en  out  1  one-cycle pulse when a byte lands in RXREG

Behaviour:
- Reset values:
  - TXSTA = 8'b0000_0010; RCSTA = 0; SPBRG = 0; TXREG = 0; RXREG = 0.
  - UART_TXD = 1; TX FSM in STOP; tsr_full = 0; pending = 0; consumed = 0.
  - txif_set_en = 1; rxif_set_en = 0; baud counter = 0.
- TXSTA bits:
  - 7 CSRC, 6 TX9, 4 SYNC, 0 TX9D: stored only; SYNC and 9-bit modes are not supported.
  - 5 TXEN, 2 BRGH: writable, functional.
  - 1 TRMT: read-only, equals !tsr_full.
  - 3: reads 0.
- Baud generator:
  - N = 16*(SPBRG+1) when BRGH=1, else 64*(SPBRG+1).
  - Free-running counter from reset, increments every clock, wraps N-1 to 0.
  - The TX FSM advances only on edges where the counter equals 0 (a "tick").
- TXREG handoff:
  - A write at edge W loads TXREG and sets pending; txif_set_en = !pending.
  - At edge W+1, if pending && !tsr_full && TXEN: TSR <= TXREG, tsr_full <= 1, consumed <= 1.
  - At edge W+2: consumed clears pending and then itself.
  - A TXREG write in the same cycle keeps pending = 1 with the new value.
- TX FSM:
  - States STOP (also the idle state), START, DATA (bit index 0..7).
  - STOP, tick && tsr_full: go to START, TXD = 0.
  - START, tick: go to DATA bit 0.
  - DATA, tick: shift to the next bit, LSB first; after bit 7, go to STOP, TXD = 1, tsr_full <= 0.
  - Each bit lasts exactly N clocks. The stop bit lasts at least N clocks.
  - A new TXREG may be loaded during the stop bit, giving back-to-back frames.
- TXEN cleared (write of TXEN=0):
  - Next edge: FSM to STOP, TXD = 1, tsr_full = 0.
  - Any pending TXREG is retained.
- RCSTA bits:
  - 7 SPEN, 4 CREN: functional.
  - 6 RX9, 5 SREN, 3 ADDEN: stored only.
  - 2 FERR: read-only.
  - 1 OERR and 0 RX9D: read 0.
- Receiver, enabled when SPEN && CREN:
  - UART_RXD passes through a 2-flop synchroniser.
  - When idle and a falling edge is seen, wait N/2 clocks and re-check for low; if high, return to idle (glitch).
  - Then sample every N clocks: 8 data bits LSB first, then the stop bit.
  - On the stop sample: RXREG <= data; FERR <= !stop; rxif_set_en pulses high for one cycle.
  - Disabling SPEN or CREN aborts the receiver to idle.
- rxreg_reg_wr_en overwrites RXREG and does not pulse rxif.

Decomposition:
- Package pic_uart_pkg holds:
  - TX state enum (STOP, START, DATA) and RX state enum (IDLE, START, DATA, STOP);
  - TXSTA/RCSTA bit-index constants;
  - reset constant TXSTA_RST = 8'h02;
  - baud multipliers 16 and 64.
- The receiver is one natural sub-module, pic_uart_rx.
- The baud generator, TX handoff and TX FSM stay in the top.

Test Plan:
- Reset released -> txsta_reg_out = 8'h02, txif_set_en = 1, TXD = 1, spbrg_reg_out = 0, txreg_reg_out = 0.
- TXSTA = 8'h24, SPBRG = 0, then write TXREG = 8'hCA -> one cycle later txif_set_en = 0 and tsr_full = 1; one cycle after that txif_set_en = 1.
- Continuing that case, at the first counter==0 edge -> START with TXD = 0; then every 16 clocks TXD = 0,1,0,1,0,0,1,1, then stop bit 1; TRMT = 0 during the frame and 1 after it.
- BRGH = 0, SPBRG = 2 -> each bit lasts 192 clocks.
- Write a second TXREG during the stop bit -> the next START follows with no idle gap; TXEN cleared mid-frame -> TXD = 1 and state STOP on the next edge.
- SPEN = CREN = 1, drive frame 8'h5A on RXD at N = 16 -> rxreg_reg_out = 8'h5A, one rxif_set_en pulse, FERR = 0; a low stop bit -> FERR = 1.
